chroma_gain_pipe: RTL and testbench

//   Streaming saturation-enhancement stage for CIE a*/b* chroma pairs; sits between Lab conversion and Lab->RGB.

---
 rtl/chroma_gain_pkg.sv | 51 +++++
 rtl/chroma_gain_lane.sv | 51 +++++
 rtl/chroma_gain_pipe.sv | 149 ++++++++++++++
 tb/tb_chroma_gain_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/chroma_gain_pkg.sv
// Shared constants, types and the round/shift/clip helper for the chroma gain stage.
package chroma_gain_pkg;

  localparam int DATA_W     = 20;
  localparam int GAIN_W     = 12;
  localparam int SCALE_BIT  = 8;
  localparam int GAIN_UNITY = 256;
  localparam int GAIN_RST   = 282;
  localparam int CNT_W      = 24;
  localparam int PROD_W     = DATA_W + GAIN_W + 1;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic        [GAIN_W-1:0] gain_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic        [CNT_W-1:0]  cnt_t;

  localparam gain_t GAIN_RST_V   = gain_t'(GAIN_RST);
  localparam gain_t GAIN_UNITY_V = gain_t'(GAIN_UNITY);

  // Rounded sample plus a flag telling whether it had to be clipped.
  typedef struct packed {
    logic    clip;
    sample_t val;
  } sat_t;

  // One extra bit of headroom so adding the rounding constant cannot wrap.
  localparam logic signed [PROD_W:0] RND_HALF = (PROD_W+1)'(64'sd1 <<< (SCALE_BIT-1));
  localparam logic signed [PROD_W:0] R_MAX    = (PROD_W+1)'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [PROD_W:0] R_MIN    = -R_MAX - 1;

  // Round half up (add half, arithmetic shift = floor), then clip to the signed sample range.
  function automatic sat_t sat_round_shift(input prod_t p);
    logic signed [PROD_W:0] sum;
    logic signed [PROD_W:0] r;
    sat_t res;
    sum = $signed({p[PROD_W-1], p}) + RND_HALF;
    r   = sum >>> SCALE_BIT;
    if (r > R_MAX) begin
      res.clip = 1'b1;
      res.val  = R_MAX[DATA_W-1:0];
    end else if (r < R_MIN) begin
      res.clip = 1'b1;
      res.val  = R_MIN[DATA_W-1:0];
    end else begin
      res.clip = 1'b0;
      res.val  = r[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/chroma_gain_lane.sv
// One chroma channel: S1 captures the product (gain travels with the beat),
// S2 rounds, shifts and clips, or passes the sample through in bypass.
module chroma_gain_lane
  import chroma_gain_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    s1_en,
  input  logic    s2_en,
  input  sample_t x,
  input  gain_t   gain,
  input  logic    bypass,
  output sample_t y,
  output logic    clip
);

  prod_t   s1_prod;
  sample_t s1_x;
  logic    s1_byp;
  sat_t    s2_sat;

  // S1: multiply with the gain selected for this beat and keep the raw sample for bypass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_prod <= '0;
      s1_x    <= '0;
      s1_byp  <= 1'b0;
    end else if (s1_en) begin
      s1_prod <= prod_t'(x) * prod_t'($signed({1'b0, gain}));
      s1_x    <= x;
      s1_byp  <= bypass;
    end
  end

  // Combinational rounding/clipping of the S1 product, registered into S2 below.
  always_comb begin
    s2_sat = sat_round_shift(s1_prod);
  end

  // S2: register the enhanced (or bypassed) sample and its clip flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y    <= '0;
      clip <= 1'b0;
    end else if (s2_en) begin
      y    <= s1_byp ? s1_x : s2_sat.val;
      clip <= ~s1_byp & s2_sat.clip;
    end
  end

endmodule

// File: rtl/chroma_gain_pipe.sv
// Streaming a*/b* saturation enhancement: two-stage gain pipe with valid/ready
// flow control, frame-synchronous shadow gains, bypass and per-frame clip count.
module chroma_gain_pipe
  import chroma_gain_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof,
  output logic signed [DATA_W-1:0] out_a,
  output logic signed [DATA_W-1:0] out_b,
  input  logic                     cfg_wr,
  input  logic        [GAIN_W-1:0] cfg_gain_a,
  input  logic        [GAIN_W-1:0] cfg_gain_b,
  input  logic                     cfg_bypass,
  output logic        [CNT_W-1:0]  clip_cnt
);

  // Handshake: a beat moves on a rising edge when valid & ready are both high.
  // S2 (the output register) frees up when it is empty or downstream takes it
  // (advance); S1 may accept whenever it is empty or drains into S2. in_ready
  // is combinational from out_ready; outputs hold while out_valid & ~out_ready.

  localparam cnt_t CNT_MAX = '1;

  logic  s1_valid;
  logic  s1_sof;
  logic  advance;
  logic  accept;
  logic  out_hs;
  logic  clip_a;
  logic  clip_b;
  logic  clip_any;
  cnt_t  run_cnt;

  gain_t gain_a_pend, gain_b_pend, gain_a_act, gain_b_act;
  logic  byp_pend, byp_act;
  gain_t eff_gain_a, eff_gain_b;
  logic  eff_byp;

  // Flow-control terms and the settings a newly accepted beat will capture.
  always_comb begin
    advance  = ~out_valid | out_ready;
    in_ready = ~s1_valid | advance;
    accept   = in_valid & in_ready;
    out_hs   = out_valid & out_ready;
    clip_any = clip_a | clip_b;
    // An sof beat takes the pending settings, including a cfg_wr arriving in the same cycle.
    if (in_sof) begin
      eff_gain_a = cfg_wr ? cfg_gain_a : gain_a_pend;
      eff_gain_b = cfg_wr ? cfg_gain_b : gain_b_pend;
      eff_byp    = cfg_wr ? cfg_bypass : byp_pend;
    end else begin
      eff_gain_a = gain_a_act;
      eff_gain_b = gain_b_act;
      eff_byp    = byp_act;
    end
  end

  // Shadow registers: cfg_wr fills pending, an accepted sof beat promotes them to active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gain_a_pend <= GAIN_RST_V;
      gain_b_pend <= GAIN_RST_V;
      byp_pend    <= 1'b0;
      gain_a_act  <= GAIN_RST_V;
      gain_b_act  <= GAIN_RST_V;
      byp_act     <= 1'b0;
    end else begin
      if (cfg_wr) begin
        gain_a_pend <= cfg_gain_a;
        gain_b_pend <= cfg_gain_b;
        byp_pend    <= cfg_bypass;
      end
      if (accept && in_sof) begin
        gain_a_act <= eff_gain_a;
        gain_b_act <= eff_gain_b;
        byp_act    <= eff_byp;
      end
    end
  end

  // Valid/sof bookkeeping for both stages; reset discards in-flight beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        s1_sof   <= in_sof;
      end
      if (advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_sof <= s1_sof;
        end
      end
    end
  end

  chroma_gain_lane u_lane_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .s1_en  (accept),
    .s2_en  (advance & s1_valid),
    .x      (in_a),
    .gain   (eff_gain_a),
    .bypass (eff_byp),
    .y      (out_a),
    .clip   (clip_a)
  );

  chroma_gain_lane u_lane_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .s1_en  (accept),
    .s2_en  (advance & s1_valid),
    .x      (in_b),
    .gain   (eff_gain_b),
    .bypass (eff_byp),
    .y      (out_b),
    .clip   (clip_b)
  );

  // Clip accounting at the output handshake; an sof beat closes the previous frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_cnt  <= '0;
      clip_cnt <= '0;
    end else if (out_hs) begin
      if (out_sof) begin
        clip_cnt <= run_cnt;
        run_cnt  <= cnt_t'(clip_any);
      end else if (clip_any && run_cnt != CNT_MAX) begin
        run_cnt <= run_cnt + cnt_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_chroma_gain_pipe.sv
// Directed bench for chroma_gain_pipe: hand-computed vectors for gain, rounding,
// clipping, shadow-gain timing, bypass, backpressure and reset flush.
module tb_chroma_gain_pipe;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic               in_sof;
  logic signed [19:0] in_a;
  logic signed [19:0] in_b;
  logic               out_valid;
  logic               out_ready;
  logic               out_sof;
  logic signed [19:0] out_a;
  logic signed [19:0] out_b;
  logic               cfg_wr;
  logic        [11:0] cfg_gain_a;
  logic        [11:0] cfg_gain_b;
  logic               cfg_bypass;
  logic        [23:0] clip_cnt;

  int total = 0;
  int bad   = 0;

  chroma_gain_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_a      (out_a),
    .out_b      (out_b),
    .cfg_wr     (cfg_wr),
    .cfg_gain_a (cfg_gain_a),
    .cfg_gain_b (cfg_gain_b),
    .cfg_bypass (cfg_bypass),
    .clip_cnt   (clip_cnt)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic cfg(input logic [11:0] ga, input logic [11:0] gb, input logic byp);
    cfg_gain_a = ga;
    cfg_gain_b = gb;
    cfg_bypass = byp;
    cfg_wr     = 1'b1;
    tick();
    cfg_wr     = 1'b0;
  endtask

  // Single beat with out_ready=1: checks acceptance, the 2-cycle latency and the
  // values, then lets the output handshake happen. A cfg_wr already raised by the
  // caller is presented in the same cycle as the beat.
  task automatic send_check(input string tag, input logic sof,
                            input logic signed [19:0] a, input logic signed [19:0] b,
                            input logic signed [19:0] ea, input logic signed [19:0] eb);
    in_valid = 1'b1;
    in_sof   = sof;
    in_a     = a;
    in_b     = b;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    cfg_wr   = 1'b0;
    chk({tag, "_lat1_valid"}, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_a"}, out_a, ea);
    chk({tag, "_b"}, out_b, eb);
    chk({tag, "_sof"}, out_sof, sof);
    tick();
  endtask

  int idx_in;
  int idx_out;
  int first_cyc;
  int last_cyc;

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sof     = 1'b0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b1;
    cfg_wr     = 1'b0;
    cfg_gain_a = '0;
    cfg_gain_b = '0;
    cfg_bypass = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_clip_cnt", clip_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // Reset gain 282 on a typical pair.
    send_check("t1", 1'b1, 52016, 27634, 57299, 30441);
    chk("t1_clip_cnt", clip_cnt, 0);

    // Floor-based rounding on negatives and zero.
    send_check("t2_neg", 1'b0, -100, -1, -110, -1);
    send_check("t2_zero", 1'b0, 0, 0, 0, 0);

    // Saturation at both ends.
    send_check("t3_pos", 1'b0, 500000, 0, 524287, 0);
    send_check("t3_neg", 1'b0, -500000, 0, -524288, 0);

    // Mid-frame cfg writes stay pending; the second write overwrites the first.
    cfg(12'd300, 12'd282, 1'b0);
    cfg(12'd256, 12'd282, 1'b0);
    send_check("t4_pend0", 1'b0, 1000, 1000, 1102, 1102);
    send_check("t4_pend1", 1'b0, 1000, 1000, 1102, 1102);
    send_check("t4_pend2", 1'b0, 1000, 1000, 1102, 1102);
    chk("t4_clip_cnt_mid", clip_cnt, 0);
    send_check("t4_sof", 1'b1, 1000, 1000, 1000, 1102);
    chk("t3_clip_cnt", clip_cnt, 2);
    send_check("t4_after", 1'b0, 1000, 1000, 1000, 1102);

    // Backpressure: 6 stalled cycles with 5 beats offered.
    idx_in    = 0;
    idx_out   = 0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int cyc = 0; cyc < 40 && idx_out < 5; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid  = (idx_in < 5);
      in_sof    = 1'b0;
      in_a      = 20'(100 * (idx_in + 1));
      in_b      = -20'sd100;
      #1;
      if (cyc == 2) begin
        chk("t5_in_ready_low", in_ready, 0);
        chk("t5_accepted_before_stall", idx_in, 2);
      end
      if (cyc >= 2 && cyc < 6) begin
        chk("t5_hold_valid", out_valid, 1);
        chk("t5_hold_a", out_a, 100);
      end
      if (out_valid && out_ready) begin
        chk("t5_order_a", out_a, 100 * (idx_out + 1));
        chk("t5_b", out_b, -110);
        if (idx_out == 0) first_cyc = cyc;
        last_cyc = cyc;
        idx_out++;
      end
      if (in_valid && in_ready) idx_in++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t5_drained", idx_out, 5);
    chk("t5_first_out_cyc", first_cyc, 6);
    chk("t5_no_gaps", last_cyc - first_cyc, 4);
    chk("t5_empty_after", out_valid, 0);

    // Bypass applied to the very sof beat that shares the cfg_wr cycle.
    cfg_gain_a = 12'd100;
    cfg_gain_b = 12'd100;
    cfg_bypass = 1'b1;
    cfg_wr     = 1'b1;
    send_check("byp_sof", 1'b1, -300000, 524287, -300000, 524287);
    chk("byp_clip_cnt", clip_cnt, 0);
    send_check("byp_mid", 1'b0, 7, -7, 7, -7);
    cfg(12'd512, 12'd512, 1'b0);
    send_check("byp_pending", 1'b0, 1000, -1000, 1000, -1000);

    // Reset with two beats in flight.
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_a     = 20'sd1000;
    in_b     = 20'sd1000;
    tick();
    in_a     = 20'sd2000;
    tick();
    in_valid = 1'b0;
    chk("t6_inflight_valid", out_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_clip_cnt", clip_cnt, 0);
    chk("t6_rst_a", out_a, 0);
    tick();
    chk("t6_no_stale", out_valid, 0);
    send_check("t6_gain", 1'b1, 52016, 27634, 57299, 30441);
    chk("t6_clip_cnt_after", clip_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
